xor_gate: RTL and testbench

Two-input exclusive-OR primitive with an optional registered, vector-wide XOR datapath. It is a leaf cell for gate-level logic composition. The scalar path (`A`, `B` to `Y`) is purely combinational. A clocked vector path adds a valid qualifier, a parity output and a saturating count of non-zero results, for use in checksum and difference-detection logic.

---
 rtl/xor_gate.sv | 79 +++++++
 tb/tb_xor_gate.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_gate.sv
// xor_gate: combinational scalar XOR plus a registered vector XOR path with valid
// qualifier, saturating non-zero result counter and optional parity (XOR_GATE_PARITY_EN).
module xor_gate #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             A,
  input  logic             B,
  output logic             Y,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a_vec,
  input  logic [WIDTH-1:0] b_vec,
  output logic             out_valid,
  output logic [WIDTH-1:0] y_vec,
`ifdef XOR_GATE_PARITY_EN
  output logic             parity,
`endif
  output logic [CNT_W-1:0] diff_cnt,
  input  logic             clr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             rel_q;
  logic             accept;
  logic [WIDTH-1:0] diff;

  assign Y = A ^ B;

  assign diff   = a_vec ^ b_vec;
  assign accept = in_valid & rel_q;

  // Release flop is the first stage; the datapath registers it gates form the
  // second, so the second rising edge after deassertion is the first one accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_q <= 1'b0;
    end else begin
      rel_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y_vec     <= '0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        y_vec <= diff;
      end
    end
  end

`ifdef XOR_GATE_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity <= 1'b0;
    end else if (accept) begin
      parity <= ^diff;
    end
  end
`endif

  // Clear wins over a same-cycle counting event; count holds at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_cnt <= '0;
    end else if (clr_cnt) begin
      diff_cnt <= '0;
    end else if (accept && (|diff) && (diff_cnt != CNT_MAX)) begin
      diff_cnt <= diff_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_xor_gate.sv
// Self-checking bench for xor_gate: scalar truth table, vector path, counter
// saturation/clear priority and asynchronous reset, against a behavioural model.
module tb_xor_gate;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             A, B, Y, clk, rst_n;
  logic             in_valid, out_valid, clr_cnt;
  logic [WIDTH-1:0] a_vec, b_vec, y_vec;
  logic [CNT_W-1:0] diff_cnt;
`ifdef XOR_GATE_PARITY_EN
  logic             parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [WIDTH-1:0] m_y;
  logic             m_valid;
  logic             m_par;
  int               m_cnt;
  int               rel_edges;

  xor_gate #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .A(A), .B(B), .Y(Y), .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .a_vec(a_vec), .b_vec(b_vec),
    .out_valid(out_valid), .y_vec(y_vec),
`ifdef XOR_GATE_PARITY_EN
    .parity(parity),
`endif
    .diff_cnt(diff_cnt), .clr_cnt(clr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_y = '0; m_valid = 1'b0; m_par = 1'b0; m_cnt = 0; rel_edges = 0;
  endtask

  // Called at a falling edge: drive, pass one rising edge, update model, return at next falling edge.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic clr);
    logic [WIDTH-1:0] r;
    logic             acc;
    in_valid = v; a_vec = a; b_vec = b; clr_cnt = clr;
    @(posedge clk);
    if (rst_n) begin
      r   = a ^ b;
      acc = v && (rel_edges >= 1);
      if (clr) m_cnt = 0;
      else if (acc && r != 0 && m_cnt < CMAX) m_cnt = m_cnt + 1;
      m_valid = acc;
      if (acc) begin
        m_y   = r;
        m_par = ($countones(r) % 2) == 1;
      end
      rel_edges++;
    end
    @(negedge clk);
  endtask

  task automatic test_scalar(input logic rst_level);
    logic exp_tt [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    rst_n = rst_level;
    for (int i = 0; i < 4; i++) begin
      A = i[1]; B = i[0];
      #100;
      n_checks++;
      if (Y !== exp_tt[i]) begin
        n_fail++;
        $display("FAIL scalar_tt rst_n=%0b AB=%0b%0b: Y=%b expected %b", rst_level, A, B, Y, exp_tt[i]);
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0 || y_vec !== '0 || diff_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%b y_vec=%h diff_cnt=%0d expected 0/00/0", out_valid, y_vec, diff_cnt);
    end
`ifdef XOR_GATE_PARITY_EN
    n_checks++;
    if (parity !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_parity: parity=%b expected 0", parity);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 8'h12, 8'h34, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || y_vec !== 8'h00) begin
      n_fail++;
      $display("FAIL release_edge1: out_valid=%b y_vec=%h expected 0/00", out_valid, y_vec);
    end
    cycle(1'b1, 8'h12, 8'h34, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || y_vec !== 8'h26 || diff_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL release_edge2: out_valid=%b y_vec=%h diff_cnt=%0d expected 1/26/1", out_valid, y_vec, diff_cnt);
    end
  endtask

  task automatic test_vector();
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    cycle(1'b1, 8'hF0, 8'h3C, 1'b0);
    n_checks++;
    if (y_vec !== 8'hCC || out_valid !== 1'b1 || diff_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL vector_pulse: y_vec=%h out_valid=%b diff_cnt=%0d expected CC/1/1", y_vec, out_valid, diff_cnt);
    end
`ifdef XOR_GATE_PARITY_EN
    n_checks++;
    if (parity !== 1'b0) begin
      n_fail++;
      $display("FAIL vector_parity: parity=%b expected 0", parity);
    end
`endif
    cycle(1'b0, 8'h55, 8'h00, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || y_vec !== 8'hCC || diff_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL vector_hold: out_valid=%b y_vec=%h diff_cnt=%0d expected 0/CC/1", out_valid, y_vec, diff_cnt);
    end
  endtask

  task automatic test_equal();
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    cycle(1'b1, 8'hA5, 8'hA5, 1'b0);
    n_checks++;
    if (y_vec !== 8'h00 || out_valid !== 1'b1 || diff_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL equal_zero: y_vec=%h out_valid=%b diff_cnt=%0d expected 00/1/0", y_vec, out_valid, diff_cnt);
    end
    cycle(1'b1, 8'h01, 8'h00, 1'b0);
    n_checks++;
    if (y_vec !== 8'h01 || out_valid !== 1'b1 || diff_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL equal_then_one: y_vec=%h out_valid=%b diff_cnt=%0d expected 01/1/1", y_vec, out_valid, diff_cnt);
    end
`ifdef XOR_GATE_PARITY_EN
    n_checks++;
    if (parity !== 1'b1) begin
      n_fail++;
      $display("FAIL equal_parity: parity=%b expected 1", parity);
    end
`endif
  endtask

  task automatic test_saturation();
    logic [WIDTH-1:0] a, nz;
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) begin
      a  = WIDTH'($urandom_range(0, 255));
      nz = WIDTH'($urandom_range(1, 255));
      cycle(1'b1, a, a ^ nz, 1'b0);
      n_checks++;
      if (diff_cnt !== CNT_W'(m_cnt) || y_vec !== m_y || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_step%0d: diff_cnt=%0d y_vec=%h out_valid=%b expected %0d/%h/1", i, diff_cnt, y_vec, out_valid, m_cnt, m_y);
      end
    end
    n_checks++;
    if (diff_cnt !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_final: diff_cnt=%0d expected 15", diff_cnt);
    end
    cycle(1'b1, 8'h0F, 8'hF0, 1'b1);
    n_checks++;
    if (diff_cnt !== 4'd0 || y_vec !== 8'hFF) begin
      n_fail++;
      $display("FAIL clr_priority: diff_cnt=%0d y_vec=%h expected 0/FF", diff_cnt, y_vec);
    end
  endtask

  task automatic test_random();
    logic v, clr;
    logic [WIDTH-1:0] a, b;
    for (int i = 0; i < 200; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      a   = WIDTH'($urandom);
      b   = ($urandom_range(0, 4) == 0) ? a : WIDTH'($urandom);
      cycle(v, a, b, clr);
      n_checks++;
      if (out_valid !== m_valid || y_vec !== m_y || diff_cnt !== CNT_W'(m_cnt)) begin
        n_fail++;
        $display("FAIL random%0d: out_valid=%b y_vec=%h diff_cnt=%0d expected %b/%h/%0d", i, out_valid, y_vec, diff_cnt, m_valid, m_y, m_cnt);
      end
`ifdef XOR_GATE_PARITY_EN
      n_checks++;
      if (parity !== m_par) begin
        n_fail++;
        $display("FAIL random_parity%0d: parity=%b expected %b", i, parity, m_par);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 8'h3C, 8'h99, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || y_vec !== 8'hA5) begin
      n_fail++;
      $display("FAIL pre_reset: out_valid=%b y_vec=%h expected 1/A5", out_valid, y_vec);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || y_vec !== '0 || diff_cnt !== '0) begin
      n_fail++;
      $display("FAIL async_reset: out_valid=%b y_vec=%h diff_cnt=%0d expected 0/00/0", out_valid, y_vec, diff_cnt);
    end
`ifdef XOR_GATE_PARITY_EN
    n_checks++;
    if (parity !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_parity: parity=%b expected 0", parity);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 1'b0);
    cycle(1'b1, 8'hFF, 8'h0F, 1'b0);
    n_checks++;
    if (y_vec !== 8'hF0 || out_valid !== 1'b1 || diff_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL post_reset: y_vec=%h out_valid=%b diff_cnt=%0d expected F0/1/1", y_vec, out_valid, diff_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; A = 1'b0; B = 1'b0;
    in_valid = 1'b0; a_vec = '0; b_vec = '0; clr_cnt = 1'b0;
    model_reset();
    test_scalar(1'b0);
    test_reset();
    test_vector();
    test_equal();
    test_saturation();
    test_random();
    test_async_reset();
    test_scalar(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
